// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache-to-memory interface: default geometry,
// responder FSM state encodings and an index-width helper.
package cache_mem_pkg;

    localparam int DEF_DATA_W          = 32;
    localparam int DEF_ADDR_W          = 32;
    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_DEPTH_WORDS     = 1024;
    localparam int DEF_LATENCY         = 4;

    // Responder FSM encodings (3-bit, kept as plain constants for legacy tools)
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT   = 3'd1;
    localparam logic [2:0] ST_RBURST = 3'd2;
    localparam logic [2:0] ST_WBURST = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/main_memory_responder_if.sv
// Cache-to-memory burst interface. The cache controller drives the master
// modport; the main-memory responder implements the slave modport.
interface main_memory_responder_if
    import cache_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int BEAT_W = 2
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [BEAT_W-1:0] mem_beat;
    logic              mem_busy;
    logic              mem_done;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_wready, mem_rvalid, mem_rdata, mem_beat, mem_busy, mem_done
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_wready, mem_rvalid, mem_rdata, mem_beat, mem_busy, mem_done
    );
endinterface

// File: rtl/main_memory_responder_mem_word_array.sv
// Single-port word store with write enable and registered read.
// Optional feature macro: MEM_ADDR_PATTERN_EN -- adds a per-word written bit;
// reads of never-written words return the supplied address pattern instead.
module mem_word_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_pattern,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_store [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // Store write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_store[i_idx] <= i_wdata;
        end
    end

`ifdef MEM_ADDR_PATTERN_EN
    logic [DEPTH_WORDS-1:0] r_written;

    // Track which words have been written since the last reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_written <= '0;
        end else if (i_we) begin
            r_written[i_idx] <= 1'b1;
        end
    end

    // Registered read; unwritten words return their own address pattern
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_written[i_idx] ? r_store[i_idx] : i_pattern;
        end
    end
`else
    logic w_unused_pattern;
    assign w_unused_pattern = ^i_pattern;

    // Registered read; data holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_store[i_idx];
        end
    end
`endif

    assign o_rdata = r_rdata;

endmodule

// File: rtl/main_memory_responder.sv
// Main-memory responder: serves whole-block read (line fill) and write
// (write-back) bursts after a programmable latency from a word store.
// Optional feature macro: MEM_ADDR_PATTERN_EN (see mem_word_array).
module main_memory_responder
    import cache_mem_pkg::*;
#(
    parameter int DATA_W          = DEF_DATA_W,
    parameter int ADDR_W          = DEF_ADDR_W,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int DEPTH_WORDS     = DEF_DEPTH_WORDS,
    parameter int LATENCY         = DEF_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst_n,
    main_memory_responder_if.slave bus
);
    localparam int BEAT_W = idx_w(WORDS_PER_BLOCK);
    localparam int IDX_W  = idx_w(DEPTH_WORDS);
    localparam int BOFF_W = BEAT_W + 2;
    localparam int HI_W   = ADDR_W - BOFF_W;
    localparam int CNT_W  = idx_w(LATENCY + 1);

    localparam logic [CNT_W-1:0]  CNT_LOAD  = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : {CNT_W{1'b0}};
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BEAT_W-1:0] r_beat;
    logic              r_we;
    logic [HI_W-1:0]   r_addr_hi;
    logic              r_wready;
    logic              r_rvalid;
    logic              r_done;
    logic              r_busy;

    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [BEAT_W-1:0] w_beat_nxt;
    logic              w_we_nxt;
    logic [HI_W-1:0]   w_addr_hi_nxt;

    logic              w_wr_en;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_acc_addr;
    logic [DATA_W-1:0] w_rdata;
    logic              w_unused_addr_lo;

    // Offset bits inside the block are ignored: bursts always start at beat 0
    assign w_unused_addr_lo = ^bus.mem_addr[BOFF_W-1:0];

    // Next-state, latency counter and beat sequencing
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_beat_nxt    = r_beat;
        w_we_nxt      = r_we;
        w_addr_hi_nxt = r_addr_hi;
        case (r_state)
            ST_IDLE: begin
                w_beat_nxt = {BEAT_W{1'b0}};
                if (bus.mem_req) begin
                    w_we_nxt      = bus.mem_we;
                    w_addr_hi_nxt = bus.mem_addr[ADDR_W-1:BOFF_W];
                    w_cnt_nxt     = CNT_LOAD;
                    if (LATENCY > 0) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = bus.mem_we ? ST_WBURST : ST_RBURST;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_state_nxt = r_we ? ST_WBURST : ST_RBURST;
                    w_beat_nxt  = {BEAT_W{1'b0}};
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_RBURST, ST_WBURST: begin
                if (r_beat == LAST_BEAT) begin
                    w_state_nxt = ST_DONE;
                    w_beat_nxt  = {BEAT_W{1'b0}};
                end else begin
                    w_beat_nxt = r_beat + BEAT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = {BEAT_W{1'b0}};
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_beat_nxt  = {BEAT_W{1'b0}};
            end
        endcase
    end

    // Store access: writes use the current beat, reads prefetch the next beat
    // so that registered read data lines up with mem_rvalid
    always_comb begin
        w_wr_en = (r_state == ST_WBURST);
        w_rd_en = (w_state_nxt == ST_RBURST);
        if (w_wr_en) begin
            w_acc_addr = {r_addr_hi, r_beat, 2'b00};
        end else begin
            w_acc_addr = {w_addr_hi_nxt, w_beat_nxt, 2'b00};
        end
    end

    // FSM state and registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= {CNT_W{1'b0}};
            r_beat    <= {BEAT_W{1'b0}};
            r_we      <= 1'b0;
            r_addr_hi <= {HI_W{1'b0}};
            r_wready  <= 1'b0;
            r_rvalid  <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_beat    <= w_beat_nxt;
            r_we      <= w_we_nxt;
            r_addr_hi <= w_addr_hi_nxt;
            r_wready  <= (w_state_nxt == ST_WBURST);
            r_rvalid  <= (w_state_nxt == ST_RBURST);
            r_done    <= (w_state_nxt == ST_DONE);
            r_busy    <= (w_state_nxt != ST_IDLE);
        end
    end

    mem_word_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_mem (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_wr_en),
        .i_re      (w_rd_en),
        .i_idx     (w_acc_addr[2 +: IDX_W]),
        .i_wdata   (bus.mem_wdata),
        .i_pattern (DATA_W'(w_acc_addr)),
        .o_rdata   (w_rdata)
    );

    assign bus.mem_wready = r_wready;
    assign bus.mem_rvalid = r_rvalid;
    assign bus.mem_rdata  = w_rdata;
    assign bus.mem_beat   = r_beat;
    assign bus.mem_busy   = r_busy;
    assign bus.mem_done   = r_done;

endmodule

// File: doc/main_memory_responder.md
Name: main_memory_responder

Overview:
- Main-memory side of the cache-to-memory interface: the responder to the cache controller's line-fill and write-back requests.
- Serves whole-block bursts (fill = read burst, evict/write-back = write burst) after a programmable access latency.
- Holds a word-addressed backing store; sits between cache_controller and the simulation/top-level memory boundary.

Parameters:
- DATA_W, 32, data word width in bits
- ADDR_W, 32, byte address width
- WORDS_PER_BLOCK, 4, burst length in words; power of 2, >=2
- DEPTH_WORDS, 1024, backing-store depth in words; power of 2; upper address bits alias
- LATENCY, 4, idle cycles between request acceptance and first beat; 0 allowed

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_req  in  1  request valid; held until mem_done is seen
- mem_we  in  1  1 = write-back burst, 0 = line fill; sampled with mem_req
- mem_addr  in  ADDR_W  byte address; block offset bits ignored (forced to 0)
- mem_wdata  in  DATA_W  write beat data; must be valid in every cycle mem_wready=1
- mem_wready  out  1  write beat accepted this cycle
- mem_rvalid  out  1  read beat valid this cycle
- mem_rdata  out  DATA_W  read beat data
- mem_beat  out  log2(WORDS_PER_BLOCK)  index of current beat
- mem_busy  out  1  request in progress (state != IDLE)
- mem_done  out  1  one-cycle pulse, burst complete

Behaviour:
- Reset (async, rst_n=0): state IDLE; mem_wready, mem_rvalid, mem_done, mem_busy = 0; mem_rdata = 0; mem_beat = 0; latency counter = 0. Backing store contents are NOT cleared. Reset mid-burst aborts the burst; beats already written stay written.
- Word index = mem_addr[2 +: log2(DEPTH_WORDS)]; base = index with low log2(WORDS_PER_BLOCK) bits zeroed; beat address = base + beat, wrapping within the block.
- FSM states: IDLE, WAIT, RBURST, WBURST, DONE.
- IDLE: on posedge with mem_req=1, capture base and mem_we; counter <= LATENCY-1. Go to WAIT if LATENCY>0, else directly to RBURST/WBURST.
- WAIT: decrement counter; at 0, go to RBURST (we=0) or WBURST (we=1). First beat therefore starts LATENCY cycles after the accept edge.
- RBURST: one beat per cycle, no bubbles. mem_rvalid=1, mem_rdata=store[base+beat] (registered), mem_beat=beat. After beat WORDS_PER_BLOCK-1, go to DONE.
- WBURST: mem_wready=1 each cycle; at posedge, store[base+beat] <= mem_wdata. The cache has no backpressure. After the last beat, go to DONE.
- DONE: mem_done=1 for exactly one cycle, then IDLE. The cache must drop mem_req at the edge where it samples mem_done=1.
- mem_req, mem_we and mem_addr are ignored outside IDLE. Changes mid-burst have no effect.
- Back-to-back requests: at most one new accept per (LATENCY + WORDS_PER_BLOCK + 2) cycles.
- mem_rdata holds its last value when mem_rvalid=0.

Optional Feature:
- Macro: MEM_ADDR_PATTERN_EN.
- Defined: adds a per-word written bit, cleared by reset and set on a write beat. A read of an unwritten word returns its own byte address, zero-extended/truncated to DATA_W (e.g. word at 0x80000000 reads 0x80000000).
- Undefined: no written bits; unwritten words read whatever the store array holds (x in simulation).

Decomposition:
- Shared package cache_mem_pkg:
  - FSM state encodings IDLE/WAIT/RBURST/WBURST/DONE (3-bit)
  - default WORDS_PER_BLOCK, LATENCY, DATA_W, ADDR_W
  - beat-index width function (clog2)
- One sub-module: mem_word_array. Single-port synchronous store with write enable and registered read, plus the optional written-bit vector.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> all outputs 0, mem_busy=0; mem_req=1 during reset is ignored.
- Write-back: req, we=1, addr 0x80000000, beats 0x11,0x22,0x33,0x44 -> mem_wready high exactly 4 cycles starting LATENCY=4 cycles after accept; mem_done one cycle after last beat.
- Line fill: read 0x8000000C -> base aligned to 0x80000000; rvalid 4 consecutive cycles, rdata 0x11,0x22,0x33,0x44, mem_beat 0..3.
- Aliasing: write block at 0x80001000 (DEPTH_WORDS=1024) with 0xCAFE0001..4, read 0x80000000 -> returns 0xCAFE0001..4.
- Reset mid-burst: assert rst_n=0 after beat 1 of a write of 0xA..0xD -> FSM IDLE, outputs 0; subsequent read returns 0xA,0xB then prior contents for beats 2,3.
- MEM_ADDR_PATTERN_EN defined: after reset, read 0x80020000 -> rdata 0x80020000,0x80020004,0x80020008,0x8002000C.
